// File: rtl/fetch_unit.sv
// LC-3b instruction fetch: reads one word at PC over a ready handshake, latches IR, returns PC+2.
// Optional fetch abort after TIMEOUT wait cycles is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int          TIMEOUT  = 16,
  parameter logic [15:0] IR_RESET = 16'h0000
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pc_in,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [15:0] ir,
  output logic [15:0] next_pc,
  output logic        pc_load,
  output logic        done,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, UPDATE} state_t;

  state_t      state, state_nx;
  logic [15:0] mem_addr_nx, ir_nx, next_pc_nx;
  logic        mem_rd_nx, pc_load_nx, done_nx, err_nx;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_nx;
`endif

  always_comb begin
    state_nx    = state;
    mem_addr_nx = mem_addr;
    mem_rd_nx   = mem_rd;
    ir_nx       = ir;
    next_pc_nx  = next_pc;
    pc_load_nx  = 1'b0;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_nx      = cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (pc_in[0]) begin
            err_nx = 1'b1;
          end else begin
            mem_addr_nx = pc_in;
            mem_rd_nx   = 1'b1;
            state_nx    = WAIT;
`ifdef FETCH_TIMEOUT_EN
            cnt_nx      = '0;
`endif
          end
        end
      end
      WAIT: begin
        // Completion is checked first so a ready on the final count still wins.
        if (mem_ready) begin
          ir_nx      = mem_rdata;
          next_pc_nx = mem_addr + 16'd2;
          mem_rd_nx  = 1'b0;
          pc_load_nx = 1'b1;
          done_nx    = 1'b1;
          state_nx   = UPDATE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          mem_rd_nx = 1'b0;
          err_nx    = 1'b1;
          state_nx  = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
`endif
      end
      UPDATE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state    <= IDLE;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      ir       <= IR_RESET;
      next_pc  <= '0;
      pc_load  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      state    <= state_nx;
      mem_addr <= mem_addr_nx;
      mem_rd   <= mem_rd_nx;
      ir       <= ir_nx;
      next_pc  <= next_pc_nx;
      pc_load  <= pc_load_nx;
      done     <= done_nx;
      err      <= err_nx;
`ifdef FETCH_TIMEOUT_EN
      cnt      <= cnt_nx;
`endif
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected done/err responses, a monitor checks them.
module tb_fetch_unit;
  localparam int TO = 4;

  logic        clock_50 = 1'b0;
  logic        reset, start, mem_ready;
  logic [15:0] pc_in, mem_rdata;
  logic [15:0] mem_addr, ir, next_pc;
  logic        mem_rd, pc_load, done, busy, err;

  fetch_unit #(.TIMEOUT(TO), .IR_RESET(16'h0000)) dut (
    .clock_50(clock_50), .reset(reset), .start(start), .pc_in(pc_in),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .ir(ir), .next_pc(next_pc), .pc_load(pc_load),
    .done(done), .busy(busy), .err(err)
  );

  always #5 clock_50 = ~clock_50;

  typedef struct {
    logic        is_err;
    logic [15:0] ir;
    logic [15:0] npc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock_50);
    #1;
  endtask

  task automatic push(input logic e, input logic [15:0] i, input logic [15:0] n);
    exp_t x;
    x.is_err = e; x.ir = i; x.npc = n;
    q.push_back(x);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".mem_addr"}, mem_addr, 16'h0000);
    check({tag, ".mem_rd"},   16'(mem_rd),  16'h0);
    check({tag, ".ir"},       ir,       16'h0000);
    check({tag, ".next_pc"},  next_pc,  16'h0000);
    check({tag, ".pc_load"},  16'(pc_load), 16'h0);
    check({tag, ".done"},     16'(done),    16'h0);
    check({tag, ".busy"},     16'(busy),    16'h0);
    check({tag, ".err"},      16'(err),     16'h0);
  endtask

  // Monitor: every done or err pulse must match the oldest queued expectation.
  always @(negedge clock_50) begin
    if (done || err) begin
      n_chk++;
      if (done && err) begin
        n_fail++;
        $display("FAIL mon.done_err_same_cycle: done=%b err=%b expected not both", done, err);
      end else if (q.size() == 0) begin
        n_fail++;
        $display("FAIL mon.unexpected: done=%b err=%b ir=%h next_pc=%h expected no response",
                 done, err, ir, next_pc);
      end else begin
        exp_t x;
        x = q.pop_front();
        if (err !== x.is_err || ir !== x.ir || next_pc !== x.npc || pc_load !== done) begin
          n_fail++;
          $display("FAIL mon.resp: err=%b ir=%h next_pc=%h pc_load=%b expected err=%b ir=%h next_pc=%h pc_load=%b",
                   err, ir, next_pc, pc_load, x.is_err, x.ir, x.npc, ~x.is_err);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; pc_in = '0; mem_rdata = '0;
    cyc(); cyc();
    check_reset_vals("rst");
    reset = 1'b0;
    cyc();

    // 1: zero-wait fetch at 0x3000
    pc_in = 16'h3000; start = 1'b1; push(1'b0, 16'h1234, 16'h3002);
    cyc(); start = 1'b0;
    check("t1.mem_rd_c1",   16'(mem_rd), 16'h1);
    check("t1.mem_addr",    mem_addr, 16'h3000);
    check("t1.busy_c1",     16'(busy), 16'h1);
    check("t1.done_c1",     16'(done), 16'h0);
    mem_ready = 1'b1; mem_rdata = 16'h1234;
    cyc(); mem_ready = 1'b0; mem_rdata = 16'hDEAD;
    check("t1.done_c2",     16'(done), 16'h1);
    check("t1.pc_load_c2",  16'(pc_load), 16'h1);
    check("t1.ir",          ir, 16'h1234);
    check("t1.next_pc",     next_pc, 16'h3002);
    check("t1.mem_rd_c2",   16'(mem_rd), 16'h0);
    cyc();
    check("t1.done_c3",     16'(done), 16'h0);
    check("t1.pc_load_c3",  16'(pc_load), 16'h0);
    check("t1.busy_c3",     16'(busy), 16'h0);

    // 2: three wait states, start pulses during WAIT/UPDATE ignored
    pc_in = 16'h4000; start = 1'b1; push(1'b0, 16'h5678, 16'h4002);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t2.mem_rd_c%0d", i), 16'(mem_rd), 16'h1);
      check($sformatf("t2.addr_c%0d", i),   mem_addr, 16'h4000);
      check($sformatf("t2.done_c%0d", i),   16'(done), 16'h0);
      pc_in = 16'h5000;
      start = (i % 2 == 1);
      mem_ready = (i == 4);
      mem_rdata = (i == 4) ? 16'h5678 : 16'hBEEF;
      cyc();
    end
    mem_ready = 1'b0;
    check("t2.done_c5",     16'(done), 16'h1);
    check("t2.ir",          ir, 16'h5678);
    check("t2.mem_rd_c5",   16'(mem_rd), 16'h0);
    start = 1'b1;
    cyc(); start = 1'b0;
    check("t2.mem_rd_c6",   16'(mem_rd), 16'h0);
    check("t2.busy_c6",     16'(busy), 16'h0);
    cyc();

    // 3: misaligned PC
    pc_in = 16'h3001; start = 1'b1; push(1'b1, 16'h5678, 16'h4002);
    cyc(); start = 1'b0;
    check("t3.err_c1",      16'(err), 16'h1);
    check("t3.mem_rd",      16'(mem_rd), 16'h0);
    check("t3.busy",        16'(busy), 16'h0);
    check("t3.ir",          ir, 16'h5678);
    check("t3.next_pc",     next_pc, 16'h4002);
    cyc();
    check("t3.err_c2",      16'(err), 16'h0);

    // 4: PC wrap
    pc_in = 16'hFFFE; start = 1'b1; push(1'b0, 16'hABCD, 16'h0000);
    cyc(); start = 1'b0;
    check("t4.mem_addr",    mem_addr, 16'hFFFE);
    mem_ready = 1'b1; mem_rdata = 16'hABCD;
    cyc(); mem_ready = 1'b0;
    check("t4.next_pc",     next_pc, 16'h0000);
    check("t4.ir",          ir, 16'hABCD);
    cyc();

    // 5: reset during WAIT, late mem_ready ignored
    pc_in = 16'h2000; start = 1'b1;
    cyc(); start = 1'b0;
    check("t5.mem_rd_c1",   16'(mem_rd), 16'h1);
    reset = 1'b1;
    cyc(); reset = 1'b0;
    check_reset_vals("t5.c2");
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    cyc(); mem_ready = 1'b0;
    check_reset_vals("t5.c3");
    cyc();
    check_reset_vals("t5.c4");

    // 6: memory never answers
    pc_in = 16'h6000; start = 1'b1;
`ifdef FETCH_TIMEOUT_EN
    push(1'b1, 16'h0000, 16'h0000);
    cyc(); start = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      check($sformatf("t6.mem_rd_c%0d", i), 16'(mem_rd), 16'h1);
      cyc();
    end
    check("t6.err",         16'(err), 16'h1);
    check("t6.mem_rd_end",  16'(mem_rd), 16'h0);
    check("t6.busy_end",    16'(busy), 16'h0);
    cyc();
    // ready on the final count wins over the timeout
    pc_in = 16'h6100; start = 1'b1; push(1'b0, 16'h4321, 16'h6102);
    cyc(); start = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      mem_ready = (i == TO); mem_rdata = 16'h4321;
      cyc();
    end
    mem_ready = 1'b0;
    check("t6.race_done",   16'(done), 16'h1);
    check("t6.race_err",    16'(err), 16'h0);
    cyc();
`else
    cyc(); start = 1'b0;
    for (int i = 0; i < 100; i++) cyc();
    check("t6.mem_rd_100",  16'(mem_rd), 16'h1);
    check("t6.busy_100",    16'(busy), 16'h1);
    check("t6.err_100",     16'(err), 16'h0);
    reset = 1'b1;
    cyc(); reset = 1'b0;
    cyc();
`endif

    check("sb.pending", 16'(q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
